// File: rtl/vector_writeback_pkg.sv
// vector_writeback_pkg: shared encodings and beat-count rule for the vector write sequencer.
package vector_writeback_pkg;
  localparam int MAX_GROUP = 4;
  typedef enum logic [2:0] {
    INST_VXOR     = 3'b000,
    INST_VMACC    = 3'b001,
    INST_VREDSUM  = 3'b010,
    INST_VSLIDEUP = 3'b011,
    INST_VRGATHER = 3'b100,
    INST_INVALID  = 3'b111
  } inst_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_DONE = 2'd2} state_e;
  // Reductions produce a scalar in vd only, whatever the group size.
  function automatic logic [2:0] beats(input logic [2:0] inst, input logic lmul);
    return (lmul && inst != INST_VREDSUM) ? 3'(MAX_GROUP) : 3'd1;
  endfunction
endpackage

// File: rtl/vector_pend_mask.sv
// vector_pend_mask: pending-write mask; sets a wrapping run of registers, clears one index per cycle.
module vector_pend_mask import vector_writeback_pkg::*; #(
  parameter int N  = 32,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_set,
  input  logic [IW-1:0] i_base,
  input  logic [2:0]    i_cnt,
  input  logic          i_clr,
  input  logic [IW-1:0] i_clr_idx,
  output logic [N-1:0]  o_mask
);
  logic [N-1:0] r_mask, w_set, w_clr;
  always_comb begin
    w_set = '0;
    for (int i = 0; i < MAX_GROUP; i++)
      if (i_set && 3'(i) < i_cnt) w_set[i_base + IW'(i)] = 1'b1;
    w_clr = i_clr ? N'(1) << i_clr_idx : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_mask <= '0;
    else r_mask <= (r_mask | w_set) & ~w_clr;
  assign o_mask = r_mask;
endmodule

// File: rtl/vector_writeback.sv
// vector_writeback: takes one result group per handshake and writes it to the register file one beat per cycle.
module vector_writeback import vector_writeback_pkg::*; #(
  parameter int VLEN = 128,
  parameter int NREG = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [2:0]        wb_inst,
  input  logic [4:0]        wb_vd,
  input  logic              wb_lmul,
  input  logic [4*VLEN-1:0] wb_data,
  output logic              vsi_rf_we,
  output logic [4:0]        vsi_rf_waddr,
  output logic [VLEN-1:0]   vsi_rf_wdata,
  output logic              wb_done,
  output logic [NREG-1:0]   wb_pend
);
  state_e            r_state, w_next;
  logic [4:0]        r_vd;
  logic [1:0]        r_cnt, r_last;
  logic [4*VLEN-1:0] r_data;
  logic              w_acc, w_inv;
  logic [2:0]        w_n;
  always_comb begin
    w_acc  = wb_valid && r_state == S_IDLE;
    w_inv  = wb_inst == INST_INVALID;
    w_n    = beats(wb_inst, wb_lmul);
    w_next = r_state == S_IDLE  ? (wb_valid ? (w_inv ? S_DONE : S_WRITE) : S_IDLE) :
             r_state == S_WRITE ? (r_cnt == r_last ? S_DONE : S_WRITE) : S_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_vd    <= '0;
      r_cnt   <= '0;
      r_last  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_vd   <= wb_vd;
        r_cnt  <= '0;
        r_last <= 2'(w_n - 3'd1);
        r_data <= wb_data;
      end else if (r_state == S_WRITE) r_cnt <= r_cnt + 2'd1;
    end
  // Write port is decoded from registered state so nothing on wb_* reaches it combinationally.
  assign wb_ready     = r_state == S_IDLE;
  assign vsi_rf_we    = r_state == S_WRITE;
  assign vsi_rf_waddr = vsi_rf_we ? r_vd + 5'(r_cnt) : '0;
  assign vsi_rf_wdata = vsi_rf_we ? r_data[r_cnt*VLEN +: VLEN] : '0;
  assign wb_done      = r_state == S_DONE;
  vector_pend_mask #(.N(NREG)) u_pend (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set     (w_acc && !w_inv),
    .i_base    (wb_vd),
    .i_cnt     (w_n),
    .i_clr     (vsi_rf_we),
    .i_clr_idx (vsi_rf_waddr),
    .o_mask    (wb_pend)
  );
endmodule

// File: tb/tb_vector_writeback.sv
// tb_vector_writeback: randomized scoreboard bench; the driver queues expected beats, a negedge monitor checks them.
module tb_vector_writeback;
  localparam int VLEN = 128;
  typedef struct {
    int             cyc;
    logic [4:0]     addr;
    logic [VLEN-1:0] data;
  } beat_t;
  logic clk = 0, rst_n = 0, wb_valid = 0, wb_lmul = 0;
  logic [2:0] wb_inst = '0;
  logic [4:0] wb_vd = '0;
  logic [4*VLEN-1:0] wb_data = '0;
  logic wb_ready, vsi_rf_we, wb_done;
  logic [4:0] vsi_rf_waddr;
  logic [VLEN-1:0] vsi_rf_wdata;
  logic [31:0] wb_pend;
  int cyc = 0, checks = 0, errors = 0;
  bit run = 0;
  beat_t beat_q[$];
  int done_q[$];

  vector_writeback #(.VLEN(VLEN), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_inst(wb_inst), .wb_vd(wb_vd), .wb_lmul(wb_lmul), .wb_data(wb_data),
    .vsi_rf_we(vsi_rf_we), .vsi_rf_waddr(vsi_rf_waddr), .vsi_rf_wdata(vsi_rf_wdata),
    .wb_done(wb_done), .wb_pend(wb_pend)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [VLEN-1:0] act, logic [VLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] exp_pend();
    logic [31:0] m = '0;
    foreach (beat_q[i]) m[beat_q[i].addr] = 1'b1;
    return m;
  endfunction

  function automatic logic [4*VLEN-1:0] rand_data();
    logic [4*VLEN-1:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Reference model: n registers vd, vd+1, ... (mod 32), one per cycle after the accept edge, then done.
  task automatic send(input logic [2:0] inst, input logic [4:0] vd, input logic lmul,
                      input logic [4*VLEN-1:0] data, output int acc);
    int n;
    beat_t b;
    @(negedge clk);
    wb_valid = 1; wb_inst = inst; wb_vd = vd; wb_lmul = lmul; wb_data = data;
    for (int k = 0; k < 50 && !wb_ready; k++) @(negedge clk);
    acc = -1;
    if (!wb_ready) chk("accept_timeout", {127'b0, wb_ready}, 1);
    else begin
      @(posedge clk);
      #1;
      acc = cyc;
      n = inst == 3'b111 ? 0 : (lmul && inst != 3'b010) ? 4 : 1;
      for (int i = 0; i < n; i++) begin
        b.cyc = acc + i;
        b.addr = 5'((int'(vd) + i) % 32);
        b.data = data[i*VLEN +: VLEN];
        beat_q.push_back(b);
      end
      done_q.push_back(acc + n);
    end
  endtask

  task automatic idle(input int k);
    @(negedge clk);
    wb_valid = 0;
    repeat (k) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (run && rst_n) begin
      chk("ready", {127'b0, wb_ready}, {127'b0, done_q.size() == 0});
      chk("pend", {96'b0, wb_pend}, {96'b0, exp_pend()});
      if (beat_q.size() > 0 && beat_q[0].cyc == cyc) begin
        chk("beat_we", {127'b0, vsi_rf_we}, 1);
        chk("beat_addr", {123'b0, vsi_rf_waddr}, {123'b0, beat_q[0].addr});
        chk("beat_data", vsi_rf_wdata, beat_q[0].data);
        void'(beat_q.pop_front());
      end else chk("we_quiet", {127'b0, vsi_rf_we}, 0);
      if (done_q.size() > 0 && done_q[0] == cyc) begin
        chk("done", {127'b0, wb_done}, 1);
        void'(done_q.pop_front());
      end else chk("done_quiet", {127'b0, wb_done}, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, a1, a2, a3;
    logic [4*VLEN-1:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_we", {127'b0, vsi_rf_we}, 0);
    chk("rst_waddr", {123'b0, vsi_rf_waddr}, 0);
    chk("rst_wdata", vsi_rf_wdata, 0);
    chk("rst_done", {127'b0, wb_done}, 0);
    chk("rst_pend", {96'b0, wb_pend}, 0);
    chk("rst_ready", {127'b0, wb_ready}, 1);
    rst_n = 1;
    run = 1;
    idle(2);
    d = rand_data();
    d[VLEN-1:0] = {16{8'hA5}};
    send(3'b000, 5'd5, 1'b0, d, a0);
    chk("vxor_pend", {96'b0, wb_pend}, 128'h20);
    for (int i = 0; i < 4; i++) d[i*VLEN +: VLEN] = {4{32'h1111_1111 * (i + 1)}};
    send(3'b001, 5'd30, 1'b1, d, a0);
    chk("vmacc_pend", {96'b0, wb_pend}, 128'hC000_0003);
    send(3'b010, 5'd8, 1'b1, rand_data(), a0);
    chk("vredsum_pend", {96'b0, wb_pend}, 128'h100);
    idle(1);
    send(3'b111, 5'd12, 1'b1, rand_data(), a0);
    send(3'b011, 5'd4, 1'b1, rand_data(), a1);
    send(3'b011, 5'd9, 1'b1, rand_data(), a2);
    send(3'b011, 5'd31, 1'b1, rand_data(), a3);
    chk("space_invalid", 128'(a1 - a0), 2);
    chk("space_slide1", 128'(a2 - a1), 6);
    chk("space_slide2", 128'(a3 - a2), 6);
    idle(8);
    send(3'b000, 5'd3, 1'b1, rand_data(), a0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 0;
    wb_valid = 0;
    beat_q.delete();
    done_q.delete();
    #1;
    chk("abort_we", {127'b0, vsi_rf_we}, 0);
    chk("abort_pend", {96'b0, wb_pend}, 0);
    chk("abort_ready", {127'b0, wb_ready}, 1);
    chk("abort_done", {127'b0, wb_done}, 0);
    @(negedge clk);
    rst_n = 1;
    idle(6);
    for (int t = 0; t < 40; t++) begin
      send(3'($urandom_range(0, 7)), 5'($urandom), 1'($urandom), rand_data(), a0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
    end
    idle(1);
    for (int k = 0; k < 100 && (beat_q.size() > 0 || done_q.size() > 0); k++) @(negedge clk);
    chk("drain", 128'(beat_q.size() + done_q.size()), 0);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vector_writeback.md
# vector_writeback

Register-file write sequencer for the vector coprocessor; it is the write-side counterpart of the fetch stage's read-address generation. It accepts one completed result (up to a 4-register LMUL group) per transaction from the execute stage over a valid/ready handshake. It then drives the single register-file write port one register per cycle and publishes a pending-write mask so issue logic can stall on RAW hazards.

## Interface
Parameters:
- VLEN, 128, bits per vector register (width of one write beat).
- NREG, 32, architectural vector registers; fixed, since addresses are 5 bits.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wb_valid  in  1  execute stage presents a result.
- wb_ready  out  1  block can accept; high only in S_IDLE.
- wb_inst  in  3  instruction type: VXOR=000, VMACC=001, VREDSUM=010, VSLIDEUP=011, VRGATHER=100, INVALID=111.
- wb_vd  in  5  destination base register index.
- wb_lmul  in  1  0 = single register; 1 = group of 4.
- wb_data  in  4*VLEN  result; register i of the group is bits [i*VLEN +: VLEN].
- vsi_rf_we  out  1  register-file write enable.
- vsi_rf_waddr  out  5  write address.
- vsi_rf_wdata  out  VLEN  write data.
- wb_done  out  1  one-cycle pulse; transaction retired.
- wb_pend  out  32  bit r set = register r has an accepted, not-yet-written result.

## Operation
FSM states: S_IDLE=0, S_WRITE=1, S_DONE=2.
- S_IDLE:
  - wb_ready=1.
  - On wb_valid&&wb_ready, capture inst, vd, lmul and data, and clear cnt.
  - Compute beat count n: lmul?4:1. VREDSUM always uses n=1 (scalar in vd only). Other codes 101/110 also use n=lmul?4:1.
  - INVALID (111): go to S_DONE with no writes and wb_pend unchanged.
  - Otherwise: set wb_pend bits vd+i (mod 32) for i<n, and go to S_WRITE.
- S_WRITE, every cycle:
  - vsi_rf_we=1, vsi_rf_waddr=vd+cnt (5-bit wrap), vsi_rf_wdata=data[cnt*VLEN +: VLEN].
  - Clear the wb_pend bit of vsi_rf_waddr.
  - cnt increments; when cnt==n-1, go to S_DONE.
- S_DONE: wb_done=1, vsi_rf_we=0, go to S_IDLE.
- Outside S_WRITE: vsi_rf_we=0, vsi_rf_waddr=0, vsi_rf_wdata=0.
- Address wrap: vd=30 with lmul=1 writes 30, 31, 0, 1, in that order.
- wb_valid held during non-IDLE states is ignored; inputs are not re-sampled.
- Unaligned vd with lmul=1 is legal; no error output.

## Timing
- Reset (asynchronous, rst_n low): state=S_IDLE, cnt=0, wb_pend=0, vsi_rf_we=0, vsi_rf_waddr=0, vsi_rf_wdata=0, wb_done=0. wb_ready=1 during and after reset.
- Accept at edge T:
  - wb_pend bits visible from T.
  - Beats in cycles T+1 … T+n; wb_done in cycle T+n+1; wb_ready high again in cycle T+n+2.
  - Throughput: one transaction per n+2 cycles.
- INVALID accepted at T: wb_done in cycle T+1, wb_ready in T+2.
- wb_pend clears each bit at the edge ending its write beat. wb_pend is all-zero whenever the state is S_IDLE.
- rst_n asserted mid-transaction aborts immediately: pending mask cleared, no further beats, no wb_done.
- All outputs are registered or decoded from registered state only. There is no combinational path from wb_* inputs to outputs except wb_ready, which depends on state only.

## Structure
- defines.v holds the shared constants: INST_* type codes (same encoding as fetch/decode), S_IDLE/S_WRITE/S_DONE, and `VWB_MAX_GROUP 4`.
- Single module. The pending-mask set/clear logic is natural as a sub-module `vector_pend_mask`:
  - Inputs: set enable, base index, count, clear enable, clear index.
  - Output: 32-bit mask.
  - Reusable by the issue scoreboard.

## Test plan
- Reset then idle: rst_n low 3 cycles → all outputs 0, wb_ready=1, wb_pend=0.
- VXOR, vd=5, lmul=0, data[127:0]=0xA5…A5 → one beat addr 5 with that data at T+1; wb_pend=0x20 during T…T+1; wb_done at T+2.
- VMACC, vd=30, lmul=1, four distinct slices → beats at addrs 30, 31, 0, 1 in order with slices 0–3. Initial wb_pend=0xC0000003, clearing one bit per beat. wb_done at T+5.
- VREDSUM, vd=8, lmul=1 → exactly one beat to addr 8 with slice 0; wb_done at T+2.
- INVALID, wb_valid held high continuously → no we pulses, wb_done at T+1, next accept at T+2. Back-to-back VSLIDEUP lmul=1 accepts spaced 6 cycles apart.
- rst_n dropped at beat 2 of a lmul=1 transfer → we falls immediately, wb_pend=0, no wb_done, wb_ready=1.
